seq_shift_mult: RTL and testbench

Sequential shift-add unsigned multiplier that implements the callee side of the Calyx `go`/`done` interface. It is the responder to the testbench and control logic that raise `go` and wait for `done`. It is a drop-in multi-cycle primitive for generated `main` designs. Latency depends on the data: it ends early once the remaining multiplier bits are zero.

---
 rtl/calyx_seq_pkg.sv | 16 +
 rtl/seq_shift_mult.sv | 87 ++++++++
 tb/tb_seq_shift_mult.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/calyx_seq_pkg.sv
// Shared types and helpers for multi-cycle go/done sequential primitives.
package calyx_seq_pkg;

  // Handshake phases common to every go/done responder.
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_t;

  // Iteration counter width: enough to hold WIDTH-1 plus a spare top bit.
  function automatic int iter_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage : calyx_seq_pkg

// File: rtl/seq_shift_mult.sv
// Sequential shift-add unsigned multiplier with a Calyx go/done interface.
// One iteration per cycle; terminates early once the remaining multiplier
// bits are all zero. Product is modulo 2^WIDTH.
module seq_shift_mult
  import calyx_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out,
  output logic             done
);

  localparam int                ITER_W    = iter_width(WIDTH);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(WIDTH - 1);

  seq_state_t        state;
  seq_state_t        state_next;
  logic [WIDTH-1:0]  mcand;
  logic [WIDTH-1:0]  mplier;
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  acc_next;
  logic [WIDTH-1:0]  mplier_shifted;
  logic [ITER_W-1:0] iter;
  logic              last;

  // Done is a pure decode of the state register, so go never reaches it
  // combinationally.
  assign done = (state == DONE);

  // Datapath for one iteration plus next-state selection.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    state_next     = state;
    mplier_shifted = mplier >> 1;
    acc_next       = mplier[0] ? (acc + mcand) : acc;
    last           = (mplier_shifted == '0) || (iter == LAST_ITER);
    unique case (state)
      IDLE:    if (go) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      // NOTE: the datapath registers are reset too, so a product abandoned
      // mid-run never leaks into a later result or onto out.
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      iter   <= '0;
      out    <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (go) begin
            mcand  <= left;
            mplier <= right;
            acc    <= '0;
            iter   <= '0;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier_shifted;
          iter   <= iter + 1'b1;
          if (last) out <= acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule : seq_shift_mult

// File: tb/tb_seq_shift_mult.sv
// Scoreboard bench for seq_shift_mult: stimulus pushes the hand-computed
// product and the edge after which done must appear; a negedge monitor
// pops and compares whenever done is high.
module tb_seq_shift_mult;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             go;
  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic [WIDTH-1:0] out;
  logic             done;

  typedef struct {
    logic [WIDTH-1:0] prod;
    int unsigned      at;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc;
  int          checks;
  int          errors;
  logic        prev_done;

  seq_shift_mult #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .go   (go),
    .left (left),
    .right(right),
    .out  (out),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising-edge counter; after edge e and before edge e+1, cyc == e.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every done pulse against the head of the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      prev_done = 1'b0;
    end else begin
      if (done) begin
        check("no_back_to_back_done", {31'b0, prev_done}, '0);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done high at cycle %0d with nothing pending", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("product", out, e.prod);
          check("done_cycle", cyc, e.at);
        end
      end
      prev_done = done;
    end
  end

  // Wait until the scoreboard drains; an expired budget counts as a failure.
  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    check("drain_timeout", q.size(), '0);
    q.delete();
  endtask

  // One operation with a single-cycle go pulse; inputs change right after
  // acceptance to confirm they are not re-sampled. n is the iteration count.
  task automatic run_op(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r,
                        input logic [WIDTH-1:0] prod, input int unsigned n);
    @(posedge clk);
    #1;
    left  = l;
    right = r;
    go    = 1'b1;
    q.push_back('{prod: prod, at: cyc + 1 + n});
    @(posedge clk);
    #1;
    go    = 1'b0;
    left  = 32'd1;
    right = 32'd1;
    wait_drain();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    prev_done = 1'b0;
    reset     = 1'b1;
    go        = 1'b1;
    left      = 32'd9;
    right     = 32'd9;
    #1;
    check("reset_done", {31'b0, done}, '0);
    check("reset_out", out, '0);
    repeat (2) @(negedge clk);
    check("reset_ignores_go", {31'b0, done}, '0);
    go    = 1'b0;
    reset = 1'b0;

    // Basic product: 6 * 7, three iterations.
    run_op(32'd6, 32'd7, 32'd42, 3);
    // Zero multiplier still performs one iteration.
    run_op(32'd123, 32'd0, 32'd0, 1);
    // Zero multiplicand, multiplier 5 (bit length 3).
    run_op(32'd0, 32'd5, 32'd0, 3);
    // Full-width wrap: (2^32-1)^2 mod 2^32 = 1, 32 iterations.
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32);
    // Top bit shifted out: 0x80000000 * 2 wraps to 0.
    run_op(32'h8000_0000, 32'd2, 32'd0, 2);
    // Inputs and go change after acceptance: 5 * 9 = 45, four iterations.
    run_op(32'd5, 32'd9, 32'd45, 4);

    // Held go: 3 * 2 restarts every 4 cycles.
    @(posedge clk);
    #1;
    left  = 32'd3;
    right = 32'd2;
    go    = 1'b1;
    for (int k = 0; k < 3; k++) q.push_back('{prod: 32'd6, at: cyc + 1 + 2 + 4 * k});
    repeat (11) @(posedge clk);
    #1;
    go = 1'b0;
    wait_drain();

    // Async reset mid-run: 10 * 0xFF abandoned after three iterations.
    @(posedge clk);
    #1;
    left  = 32'd10;
    right = 32'h0000_00FF;
    go    = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_done", {31'b0, done}, '0);
    check("async_reset_out", out, '0);
    @(negedge clk);
    reset = 1'b0;
    // Fresh operation after reset: 2 * 3 = 6, two iterations.
    run_op(32'd2, 32'd3, 32'd6, 2);

    // Quiet tail: any stray done is caught by the monitor.
    repeat (12) @(negedge clk);
    check("tail_done_low", {31'b0, done}, '0);
    check("tail_out_hold", out, 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_seq_shift_mult
